// File: rtl/cache_nway_plru.sv
// N-way set-associative write-through read cache with pseudo-LRU replacement
// and a word-serial line refill from main memory.
module cache_nway_plru #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int WAYS   = 2,
  parameter int SETS   = 16,
  parameter int WORDS  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              flush,
  output logic              cpu_ready,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              hit,
  output logic              miss,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [15:0]       hit_cnt,
  output logic [15:0]       miss_cnt
);

  localparam int OFF_W = $clog2(WORDS);
  localparam int IDX_W = $clog2(SETS);
  localparam int WAY_W = $clog2(WAYS);
  localparam int TAG_W = ADDR_W - 2 - OFF_W - IDX_W;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOOKUP = 3'd1;
  localparam logic [2:0] S_REFILL = 3'd2;
  localparam logic [2:0] S_WMEM   = 3'd3;
  localparam logic [2:0] S_RESP   = 3'd4;

  logic [2:0]        r_state;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_relookup;
  logic [OFF_W-1:0]  r_cnt;
  logic [WAY_W-1:0]  r_victim;
  logic [15:0]       r_hit_cnt;
  logic [15:0]       r_miss_cnt;
  logic [DATA_W-1:0] r_rdata;

  logic [WAYS-1:0]   r_valid [SETS];
  logic [2:0]        r_plru  [SETS];
  logic [TAG_W-1:0]  r_tag   [WAYS*SETS];
  logic [DATA_W-1:0] r_data  [WAYS*SETS*WORDS];

  logic [IDX_W-1:0]  w_idx;
  logic [OFF_W-1:0]  w_off;
  logic [TAG_W-1:0]  w_tag;
  logic [WAYS-1:0]   w_set_valid;
  logic [2:0]        w_plru;
  logic [2:0]        w_plru_next;
  logic [WAY_W-1:0]  w_plru_victim;
  logic [WAYS-1:0]   w_hit_vec;
  logic              w_hit;
  logic [WAY_W-1:0]  w_hit_way;
  logic              w_any_inv;
  logic [WAY_W-1:0]  w_inv_way;
  logic [WAY_W-1:0]  w_victim;
  logic              w_last;

  assign w_idx       = r_addr[2+OFF_W +: IDX_W];
  assign w_off       = r_addr[2 +: OFF_W];
  assign w_tag       = r_addr[ADDR_W-1 -: TAG_W];
  assign w_set_valid = r_valid[w_idx];
  assign w_plru      = r_plru[w_idx];
  assign w_last      = (r_cnt == OFF_W'(WORDS - 1));

  genvar gi;
  generate
    for (gi = 0; gi < WAYS; gi++) begin : g_way
      assign w_hit_vec[gi] = w_set_valid[gi] && (r_tag[{WAY_W'(gi), w_idx}] == w_tag);
    end

    // Tree bits {b2,b1,b0}: b0 picks the half, b1/b2 pick inside each half;
    // a set bit means the victim lies on the higher-numbered side.
    if (WAYS == 2) begin : g_plru2
      assign w_plru_victim = w_plru[0];
      assign w_plru_next   = {w_plru[2:1], ~w_hit_way[0]};
    end else begin : g_plru4
      assign w_plru_victim = w_plru[0] ? {1'b1, w_plru[2]} : {1'b0, w_plru[1]};
      assign w_plru_next   = {w_hit_way[1] ? ~w_hit_way[0] : w_plru[2],
                              w_hit_way[1] ? w_plru[1] : ~w_hit_way[0],
                              ~w_hit_way[1]};
    end
  endgenerate

  assign w_hit = |w_hit_vec;

  always_comb begin
    w_hit_way = '0;
    w_inv_way = '0;
    w_any_inv = 1'b0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (w_hit_vec[i]) w_hit_way = WAY_W'(i);
      if (!w_set_valid[i]) begin
        w_inv_way = WAY_W'(i);
        w_any_inv = 1'b1;
      end
    end
  end

  assign w_victim = w_any_inv ? w_inv_way : w_plru_victim;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_relookup <= 1'b0;
      r_cnt      <= '0;
      r_victim   <= '0;
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
      for (int s = 0; s < SETS; s++) begin
        r_valid[s] <= '0;
        r_plru[s]  <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (flush) begin
            for (int s = 0; s < SETS; s++) r_valid[s] <= '0;
          end else if (cpu_req) begin
            r_we       <= cpu_we;
            r_addr     <= cpu_addr;
            r_wdata    <= cpu_wdata;
            r_relookup <= 1'b0;
            r_state    <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (w_hit) begin
            r_plru[w_idx] <= w_plru_next;
            if (!r_relookup && r_hit_cnt != 16'hFFFF) r_hit_cnt <= r_hit_cnt + 16'd1;
          end else if (!r_relookup && r_miss_cnt != 16'hFFFF) begin
            r_miss_cnt <= r_miss_cnt + 16'd1;
          end
          if (r_we) begin
            r_state <= S_WMEM;
          end else if (w_hit) begin
            r_state <= S_RESP;
          end else begin
            r_victim <= w_victim;
            r_cnt    <= '0;
            r_state  <= S_REFILL;
          end
        end
        S_REFILL: begin
          if (mem_ack) begin
            r_cnt <= r_cnt + OFF_W'(1);
            if (w_last) begin
              r_valid[w_idx][r_victim] <= 1'b1;
              r_relookup               <= 1'b1;
              r_state                  <= S_LOOKUP;
            end
          end
        end
        S_WMEM: begin
          if (mem_ack) r_state <= S_RESP;
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Line storage and tags carry no reset; validity alone qualifies them.
  always_ff @(posedge clk) begin
    if (r_state == S_REFILL && mem_ack) begin
      r_data[{r_victim, w_idx, r_cnt}] <= mem_rdata;
    end else if (r_state == S_LOOKUP && r_we && w_hit) begin
      r_data[{w_hit_way, w_idx, w_off}] <= r_wdata;
    end
    if (r_state == S_LOOKUP) r_rdata <= r_data[{w_hit_way, w_idx, w_off}];
    if (r_state == S_REFILL && mem_ack && w_last) r_tag[{r_victim, w_idx}] <= w_tag;
  end

  assign cpu_ready = (r_state == S_RESP);
  assign cpu_rdata = (r_state == S_RESP) ? r_rdata : '0;
  assign hit       = (r_state == S_LOOKUP) && !r_relookup && w_hit;
  assign miss      = (r_state == S_LOOKUP) && !r_relookup && !w_hit;
  assign mem_req   = (r_state == S_REFILL) || (r_state == S_WMEM);
  assign mem_we    = (r_state == S_WMEM);
  assign mem_addr  = (r_state == S_REFILL) ? {r_addr[ADDR_W-1:2+OFF_W], r_cnt, 2'b00} :
                     (r_state == S_WMEM)   ? r_addr : '0;
  assign mem_wdata = (r_state == S_WMEM) ? r_wdata : '0;
  assign hit_cnt   = r_hit_cnt;
  assign miss_cnt  = r_miss_cnt;

endmodule

// File: tb/tb_cache_nway_plru.sv
// Randomised scoreboard bench for cache_nway_plru: an LRU/timestamp cache model
// predicts hits, refill traffic and read data; monitors compare as the DUT responds.
module tb_cache_nway_plru;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int WAYS   = 2;
  localparam int SETS   = 16;
  localparam int WORDS  = 8;
  localparam int OFF_B  = $clog2(WORDS);
  localparam int IDX_B  = $clog2(SETS);

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cpu_req, cpu_we, flush;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ready, hit, miss;
  logic [DATA_W-1:0] cpu_rdata;
  logic              mem_req, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack = 1'b0;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic [15:0]       hit_cnt, miss_cnt;

  cache_nway_plru #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAYS(WAYS), .SETS(SETS), .WORDS(WORDS)) dut (
    .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .flush(flush), .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
    .hit(hit), .miss(miss), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_read;
    logic        exp_hit;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic [15:0] hc;
    logic [15:0] mc;
  } resp_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] data;
  } memx_t;

  resp_t exp_q[$];
  memx_t mem_q[$];

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int ready_cnt = 0;
  int acks_total = 0;
  int wait_left = 1;
  bit rand_waits = 1'b0;

  // Reference model: per-set ways with valid/tag and a last-use timestamp.
  bit          m_valid [SETS][WAYS];
  logic [31:0] m_tag   [SETS][WAYS];
  longint      m_use   [SETS][WAYS];
  longint      m_time = 0;
  int          m_hc = 0, m_mc = 0;
  logic [31:0] ref_mem [int];
  logic [31:0] env_mem [int];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic logic [31:0] ref_val(input logic [31:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : a + 32'd1000;
  endfunction

  function automatic logic [31:0] env_val(input logic [31:0] a);
    return env_mem.exists(int'(a)) ? env_mem[int'(a)] : a + 32'd1000;
  endfunction

  task automatic model_clear_valid();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
  endtask

  task automatic model_reset();
    model_clear_valid();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) m_use[s][w] = 0;
    m_hc = 0;
    m_mc = 0;
    exp_q.delete();
    mem_q.delete();
  endtask

  task automatic model_issue(input bit we, input logic [31:0] addr, input logic [31:0] data,
                             output bit hit_o);
    int s, way, vic;
    logic [31:0] tag, base;
    resp_t r;
    memx_t mx;
    s   = int'((addr >> (2 + OFF_B)) % SETS);
    tag = addr >> (2 + OFF_B + IDX_B);
    way = -1;
    for (int w = 0; w < WAYS; w++)
      if (m_valid[s][w] && m_tag[s][w] == tag) way = w;
    m_time++;
    if (way >= 0) begin
      if (m_hc < 65535) m_hc++;
      m_use[s][way] = m_time;
    end else if (m_mc < 65535) begin
      m_mc++;
    end
    if (we) begin
      mx.addr = addr; mx.we = 1'b1; mx.data = data;
      mem_q.push_back(mx);
      ref_mem[int'(addr)] = data;
    end else if (way < 0) begin
      vic = -1;
      for (int w = WAYS - 1; w >= 0; w--) if (!m_valid[s][w]) vic = w;
      if (vic < 0) begin
        vic = 0;
        for (int w = 1; w < WAYS; w++) if (m_use[s][w] < m_use[s][vic]) vic = w;
      end
      base = addr & ~32'(WORDS * 4 - 1);
      for (int k = 0; k < WORDS; k++) begin
        mx.addr = base + 32'(4 * k); mx.we = 1'b0; mx.data = '0;
        mem_q.push_back(mx);
      end
      m_valid[s][vic] = 1'b1;
      m_tag[s][vic]   = tag;
      m_use[s][vic]   = m_time;
    end
    r.is_read = !we;
    r.exp_hit = (way >= 0);
    r.addr    = addr;
    r.rdata   = ref_val(addr);
    r.hc      = 16'(m_hc);
    r.mc      = 16'(m_mc);
    exp_q.push_back(r);
    hit_o = (way >= 0);
  endtask

  // Memory responder: acks after a wait, checks each access against the expected traffic.
  always @(negedge clk) begin
    if (!rst_n) begin
      mem_ack   = 1'b0;
      wait_left = 1;
    end else if (mem_ack) begin
      mem_ack   = 1'b0;
      wait_left = rand_waits ? int'($urandom_range(0, 2)) : 0;
    end else if (mem_req) begin
      if (wait_left > 0) begin
        wait_left--;
      end else begin
        memx_t e;
        mem_ack = 1'b1;
        acks_total++;
        if (mem_q.size() == 0) begin
          chk("mem_unexpected_addr", mem_addr, 32'hFFFF_FFFF);
        end else begin
          e = mem_q.pop_front();
          chk("mem_addr", mem_addr, e.addr);
          chk("mem_we", 32'(mem_we), 32'(e.we));
          if (e.we) chk("mem_wdata", mem_wdata, e.data);
        end
        if (mem_we) env_mem[int'(mem_addr)] = mem_wdata;
        else        mem_rdata = env_val(mem_addr);
      end
    end
  end

  // Response monitor.
  always @(negedge clk) begin
    if (rst_n) begin
      if (hit || miss) begin
        pulses++;
        if (exp_q.size() == 0) begin
          chk("stray_hit_miss", {30'd0, hit, miss}, 32'd0);
        end else begin
          chk("hit_flag", 32'(hit), 32'(exp_q[0].exp_hit));
          chk("miss_flag", 32'(miss), 32'(!exp_q[0].exp_hit));
        end
      end
      if (cpu_ready) begin
        ready_cnt++;
        if (exp_q.size() == 0) begin
          chk("stray_ready", 32'(cpu_ready), 32'd0);
        end else begin
          resp_t e;
          e = exp_q.pop_front();
          chk("pulse_count", 32'(pulses), 32'd1);
          if (e.is_read) chk("rdata", cpu_rdata, e.rdata);
          chk("hit_cnt", 32'(hit_cnt), 32'(e.hc));
          chk("miss_cnt", 32'(miss_cnt), 32'(e.mc));
          $display("txn %s addr=%0d hit=%0d rdata=%0d hit_cnt=%0d miss_cnt=%0d",
                   e.is_read ? "RD" : "WR", e.addr, e.exp_hit, cpu_rdata, hit_cnt, miss_cnt);
        end
        pulses = 0;
      end
    end
  end

  task automatic do_txn(input bit we, input logic [31:0] addr, input logic [31:0] data,
                        output logic [31:0] rd);
    bit exp_hit;
    int lat;
    model_issue(we, addr, data, exp_hit);
    cpu_we = we; cpu_addr = addr; cpu_wdata = data; cpu_req = 1'b1;
    @(negedge clk);
    cpu_req = 1'b0;
    lat = 1;
    while (!cpu_ready && lat < 400) begin
      @(negedge clk);
      lat++;
    end
    chk("ready_timeout", 32'(cpu_ready), 32'd1);
    rd = cpu_rdata;
    if (exp_hit && !we) chk("hit_latency", 32'(lat), 32'd2);
    @(negedge clk);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    model_clear_valid();
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int base_acks, n, rc0;
    bit found, dummy;
    rst_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; flush = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_cpu_ready", 32'(cpu_ready), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_hit_cnt", 32'(hit_cnt), 32'd0);
    chk("rst_miss_cnt", 32'(miss_cnt), 32'd0);
    chk("rst_cpu_rdata", cpu_rdata, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    do_txn(0, 256, 0, rd);  chk("cold_miss_rdata", rd, 32'd1256);
    chk("cold_miss_cnt", 32'(miss_cnt), 32'd1);
    do_txn(0, 260, 0, rd);  chk("read_hit_rdata", rd, 32'd1260);
    chk("read_hit_cnt", 32'(hit_cnt), 32'd1);
    do_txn(1, 256, 15, rd);
    do_txn(0, 256, 0, rd);  chk("write_hit_reread", rd, 32'd15);
    do_txn(1, 288, 20, rd);
    do_txn(0, 288, 0, rd);  chk("write_miss_refill_rdata", rd, 32'd20);
    do_txn(0, 768, 0, rd);
    do_txn(0, 256, 0, rd);
    do_txn(0, 1280, 0, rd); chk("evict_new_rdata", rd, 32'd2280);
    n = int'(hit_cnt);
    do_txn(0, 256, 0, rd);  chk("plru_keep_256", 32'(hit_cnt), 32'(n + 1));
    n = int'(miss_cnt);
    do_txn(0, 768, 0, rd);  chk("plru_evict_768", 32'(miss_cnt), 32'(n + 1));

    // Flush and request together: the request must be dropped.
    rc0 = ready_cnt;
    flush = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 256;
    @(negedge clk);
    flush = 1'b0; cpu_req = 1'b0;
    model_clear_valid();
    repeat (6) @(negedge clk);
    chk("flush_drops_req", 32'(ready_cnt - rc0), 32'd0);
    n = int'(miss_cnt);
    do_txn(0, 256, 0, rd);
    do_txn(0, 1280, 0, rd);
    chk("post_flush_misses", 32'(miss_cnt), 32'(n + 2));

    // Reset landing on the 4th refill ack.
    model_issue(0, 1792, 0, dummy);
    base_acks = acks_total;
    cpu_we = 1'b0; cpu_addr = 1792; cpu_req = 1'b1;
    @(negedge clk);
    cpu_req = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      #1;
      if (mem_ack && acks_total - base_acks == 4) found = 1'b1;
      else @(negedge clk);
    end
    chk("reached_4th_ack", 32'(found), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("reset_drops_mem_req", 32'(mem_req), 32'd0);
    chk("reset_clears_miss_cnt", 32'(miss_cnt), 32'd0);
    model_reset();
    pulses = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_txn(0, 1792, 0, rd);
    chk("after_reset_miss", 32'(miss_cnt), 32'd1);

    // Randomised traffic over a few tags in two sets.
    rand_waits = 1'b1;
    for (int t = 0; t < 150; t++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 3) << 9) | ($urandom_range(8, 9) << 5) | ($urandom_range(0, 7) << 2);
      if ($urandom_range(0, 99) < 5) do_flush();
      else do_txn($urandom_range(0, 99) < 30, a, $urandom, rd);
    end

    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    chk("mem_q_drained", 32'(mem_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cache_nway_plru.md
Name: cache_nway_plru

Overview:
Parametrised N-way set-associative read cache with write-through and a memory refill interface. It replaces the fixed 2-way array, where the caller selected the way manually, with automatic tag lookup, pseudo-LRU victim selection and a line-refill FSM. It sits between the CPU data port and the word-wide main-memory port.
Address split, from LSB: 2-bit byte offset, log2(WORDS) word offset, log2(SETS) index, remaining bits tag. With the defaults, address 256 maps to index 8.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, word width
WAYS, 2, associativity; legal values are 2 or 4
SETS, 16, sets per way; power of two
WORDS, 8, words per line; power of two, at least 2

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
cpu_req  in  1  request strobe; sampled only in IDLE
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  ADDR_W  byte address, word aligned
cpu_wdata  in  DATA_W  write data
flush  in  1  invalidate all lines; sampled only in IDLE
cpu_ready  out  1  one-cycle completion pulse
cpu_rdata  out  DATA_W  read data, valid while cpu_ready=1
hit  out  1  pulse in LOOKUP on tag hit
miss  out  1  pulse in LOOKUP on tag miss
mem_req  out  1  memory request, held until mem_ack
mem_we  out  1  memory write
mem_addr  out  ADDR_W  word address to memory
mem_wdata  out  DATA_W  memory write data
mem_ack  in  1  memory accepted the write or returned read data
mem_rdata  in  DATA_W  memory read data, valid with mem_ack
hit_cnt  out  16  saturating hit count
miss_cnt  out  16  saturating miss count

Behaviour:
- Reset (asynchronous, rst_n=0):
  - All valid bits and PLRU bits cleared; FSM returns to IDLE.
  - All outputs go to 0, including hit_cnt and miss_cnt.
  - Reset during REFILL abandons the line; no partial line is left valid.
  - mem_req deasserts immediately on reset.
- States: IDLE, LOOKUP, REFILL, WMEM, RESP.
- IDLE:
  - flush=1 clears every valid bit in one cycle and stays in IDLE. flush has priority over cpu_req in the same cycle; that request is not accepted.
  - Otherwise, cpu_req=1 latches we, addr and wdata, then moves to LOOKUP.
- LOOKUP (one cycle): compare the tag against all valid ways in the indexed set.
  - Read hit: hit=1, update PLRU, go to RESP. cpu_ready=1 and cpu_rdata = hit word in the next cycle. Read-hit latency is 2 cycles after acceptance.
  - Read miss: miss=1, go to REFILL.
  - Write, hit or miss: hit or miss pulses as above. On a hit the cached word is updated and PLRU is updated. Go to WMEM. Write misses do not allocate.
  - A LOOKUP re-entered after a refill does not pulse hit/miss and does not count toward hit_cnt/miss_cnt.
- Victim selection, fixed on REFILL entry:
  - The lowest-numbered invalid way, if any.
  - Otherwise the PLRU victim. WAYS=2 uses one bit per set. WAYS=4 uses a 3-bit tree per set.
- PLRU update on access: points away from the accessed way.
- REFILL:
  - Word counter starts at 0. mem_req=1, mem_we=0, mem_addr = line base + 4*count.
  - On each mem_ack, write mem_rdata into the victim line at word count, then increment the counter.
  - mem_req stays high across words. mem_addr advances on the cycle after each ack.
  - After ack number WORDS, set the victim's valid bit and tag and return to LOOKUP, which now hits.
- WMEM: mem_req=1, mem_we=1, mem_addr = latched addr, mem_wdata = latched wdata. Hold until mem_ack, then go to RESP with cpu_ready=1.
- RESP: single cycle, then IDLE.
- Outside IDLE, cpu_req and flush are ignored.
- Counters saturate at 0xFFFF.
- The mem_* outputs are stable while mem_req=1 and no mem_ack has arrived.

Test Plan:
- Cold read miss. Reset, then read 256 with mem_rdata = addr+1000 and mem_ack after 1 wait cycle.
  - Required: 8 memory reads at 256, 260, …, 284.
  - Required: then cpu_ready with cpu_rdata=1256; miss_cnt=1, hit_cnt=0.
- Read hit. Read 260 after the cold-miss test.
  - Required: no mem_req; cpu_ready 2 cycles after acceptance with cpu_rdata=1260; hit_cnt=1.
- Write-through on a hit. Write 15 to 256.
  - Required: a single memory write (256, 15); then a read of 256 returns 15 with no refill.
- Write miss, no allocate. Write 20 to 288 (index 9, empty set).
  - Required: memory write (288, 20), miss=1.
  - Required: a following read of 288 misses and refills.
- PLRU eviction, WAYS=2, all same index 8. Read 256, read 768, read 256, then read 1280.
  - Required: 768's way is the victim. A later read of 256 hits; a read of 768 misses.
- Reset and flush corner cases:
  - rst_n low during the 4th refill ack: mem_req drops at once; a later read of the same address misses.
  - flush in IDLE: every subsequent read misses.
